truth_table_sweep: RTL and testbench

//  Upstream stimulus/capture stage for small combinational DUTs with single-bit inputs.
//  - On start, drives every input combination onto the DUT inputs (A,B,C, MSB first), each held DWELL cycles.
//  - Samples the DUT output Q at the end of each dwell.
//  - Leaves the full captured truth table in a register.
//  - Replaces hand-written per-vector stimulus in benches and on-board checkers.

---
 rtl/truth_table_sweep_pkg.sv | 16 +
 rtl/truth_table_sweep_if.sv | 23 ++
 rtl/truth_table_sweep_dwell_timer.sv | 27 ++
 rtl/truth_table_sweep.sv | 113 +++++++++++
 tb/tb_truth_table_sweep.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweep_pkg.sv
// Shared state encoding and sizing helpers for the truth-table sweep block.
package truth_table_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DWELL_MIN = 1;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// Stimulus/capture bus between the sweep block and the bench/checker around it.
// mismatch exists only when SWEEP_CHECK_EN is defined.
interface truth_table_sweep_if
    import truth_table_sweep_pkg::*;
#(
    parameter int N_IN = 3
);
    logic                       start;
    logic                       q_in;
    logic [N_IN-1:0]            vec_out;
    logic                       busy;
    logic                       done;
    logic [vec_count(N_IN)-1:0] table_out;
`ifdef SWEEP_CHECK_EN
    logic                       mismatch;

    modport master (input start, q_in, output vec_out, busy, done, table_out, mismatch);
    modport slave  (output start, q_in, input vec_out, busy, done, table_out, mismatch);
`else
    modport master (input start, q_in, output vec_out, busy, done, table_out);
    modport slave  (output start, q_in, input vec_out, busy, done, table_out);
`endif
endinterface

// File: rtl/truth_table_sweep_dwell_timer.sv
// Dwell counter: load sets the count, otherwise it counts down and rests at zero.
module dwell_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/truth_table_sweep.sv
// Sweeps every input vector onto a small DUT, holding each DWELL cycles, and captures Q.
// Define SWEEP_CHECK_EN to compare the captured table against GOLDEN on completion.
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int                 N_IN   = 3,
    parameter int                 DWELL  = 100,
    parameter logic [2**N_IN-1:0] GOLDEN = '0
) (
    input  logic                clk,
    input  logic                rst,
    truth_table_sweep_if.master bus
);
    localparam int              NV     = vec_count(N_IN);
    localparam int              CW     = $clog2(DWELL + 1);
    localparam logic [CW-1:0]   RELOAD = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] LAST   = N_IN'(NV - 1);

    if (DWELL < DWELL_MIN) begin : g_bad_dwell
        $error("DWELL must be at least 1");
    end

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NV-1:0]   tab_q, tab_d;
    logic            load, zero;

    dwell_timer #(.W(CW)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (RELOAD),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = HOLD;
            HOLD:    if (zero && vec_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == HOLD);
        bus.done = (state_q == DONE);
    end

    // The timer reaching zero marks the last cycle of a dwell: capture, then advance.
    always_comb begin
        vec_d = vec_q;
        tab_d = tab_q;
        load  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                vec_d = '0;
                tab_d = '0;
                load  = 1'b1;
            end
            HOLD: if (zero) begin
                tab_d[vec_q] = bus.q_in;
                if (vec_q != LAST) begin
                    vec_d = vec_q + 1'b1;
                    load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
            tab_q <= '0;
        end else begin
            vec_q <= vec_d;
            tab_q <= tab_d;
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.table_out = tab_q;

`ifdef SWEEP_CHECK_EN
    logic mm_q, mm_d;

    // Compare against tab_d so the final capture is included.
    always_comb begin
        mm_d = mm_q;
        if (state_q == IDLE && bus.start)
            mm_d = 1'b0;
        else if (state_q == HOLD && state_d == DONE)
            mm_d = (tab_d != GOLDEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mm_q <= 1'b0;
        else     mm_q <= mm_d;
    end

    assign bus.mismatch = mm_q;
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
`endif
endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: three instances (N_IN/DWELL = 3/100, 3/1, 2/3) driven by modelled DUTs.
module tb_truth_table_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int         sel       = 0;
    logic       start_r   = 1'b0;
    int         fn        = 0;
    logic [7:0] lut       = 8'h00;
    logic       settle_en = 1'b0;
    int         errs      = 0;
    int         checks    = 0;

    truth_table_sweep_if #(.N_IN(3)) if0 ();
    truth_table_sweep_if #(.N_IN(3)) if1 ();
    truth_table_sweep_if #(.N_IN(2)) if2 ();

    truth_table_sweep #(.N_IN(3), .DWELL(100), .GOLDEN(8'h96)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    truth_table_sweep #(.N_IN(3), .DWELL(1),   .GOLDEN(8'h96)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    truth_table_sweep #(.N_IN(2), .DWELL(3),   .GOLDEN(4'h8))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Modelled DUT: a named boolean function of A..C; output is wrong until it has settled DWELL-1 cycles.
    function automatic logic qmodel(input int f, input int v, input int nin, input int ag,
                                    input int dw, input logic [7:0] lt, input logic se);
        logic a, b, c, q;
        a = v[nin-1];
        b = v[nin-2];
        c = v[0];
        case (f)
            0:       q = ^v;
            1:       q = (a & b) | c;
            2:       q = 1'b0;
            3:       q = a & b;
            4:       q = lt[v[2:0]];
            5:       q = a;
            6:       q = c;
            default: q = 1'b0;
        endcase
        return (se && ag < dw - 1) ? ~q : q;
    endfunction

    int   age   [3] = '{0, 0, 0};
    int   lastv [3] = '{0, 0, 0};
    logic lastb [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        int   vv [3];
        logic bb [3];
        vv = '{int'(if0.vec_out), int'(if1.vec_out), int'(if2.vec_out)};
        bb = '{if0.busy, if1.busy, if2.busy};
        for (int i = 0; i < 3; i++) begin
            if (vv[i] != lastv[i] || !lastb[i]) age[i] = 0;
            else                                age[i] = age[i] + 1;
            lastv[i] = vv[i];
            lastb[i] = bb[i];
        end
    end

    assign if0.start = start_r && (sel == 0);
    assign if1.start = start_r && (sel == 1);
    assign if2.start = start_r && (sel == 2);
    assign if0.q_in  = qmodel(fn, int'(if0.vec_out), 3, age[0], 100, lut, settle_en);
    assign if1.q_in  = qmodel(fn, int'(if1.vec_out), 3, age[1], 1,   lut, settle_en);
    assign if2.q_in  = qmodel(fn, int'(if2.vec_out), 2, age[2], 3,   lut, settle_en);

    int         cur_vec;
    logic       cur_busy, cur_done, cur_mm;
    logic [7:0] cur_tab;

    always_comb begin
        cur_vec  = int'(if0.vec_out);
        cur_busy = if0.busy;
        cur_done = if0.done;
        cur_tab  = if0.table_out;
        cur_mm   = 1'b0;
`ifdef SWEEP_CHECK_EN
        cur_mm   = if0.mismatch;
`endif
        if (sel == 1) begin
            cur_vec  = int'(if1.vec_out);
            cur_busy = if1.busy;
            cur_done = if1.done;
            cur_tab  = if1.table_out;
`ifdef SWEEP_CHECK_EN
            cur_mm   = if1.mismatch;
`endif
        end else if (sel == 2) begin
            cur_vec  = int'(if2.vec_out);
            cur_busy = if2.busy;
            cur_done = if2.done;
            cur_tab  = {4'h0, if2.table_out};
`ifdef SWEEP_CHECK_EN
            cur_mm   = if2.mismatch;
`endif
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pulses start on instance s, then checks every cycle against the ideal timeline:
    // cycle k after the start edge shows vector k/DWELL while busy, done alone at k = 2**N_IN*DWELL.
    task automatic run_sweep(input int s, input int exp_tab, input int pulse_at, input string nm);
        int nin, dw, n, tot, bcnt, dcnt, gold;
        nin  = (s == 2) ? 2 : 3;
        dw   = (s == 0) ? 100 : (s == 1) ? 1 : 3;
        gold = (s == 2) ? 8'h08 : 8'h96;
        n    = 1 << nin;
        tot  = n * dw;
        bcnt = 0;
        dcnt = 0;
        sel  = s;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        chk({nm, " table cleared"}, int'(cur_tab), 0);
`ifdef SWEEP_CHECK_EN
        chk({nm, " mismatch cleared"}, int'(cur_mm), 0);
`endif
        for (int k = 0; k <= tot + 1; k++) begin
            int ev, eb, ed;
            ev = (k < tot) ? k / dw : n - 1;
            eb = (k < tot) ? 1 : 0;
            ed = (k == tot) ? 1 : 0;
            bcnt += int'(cur_busy);
            dcnt += int'(cur_done);
            chk({nm, " vec/busy/done"}, cur_vec * 4 + int'(cur_busy) * 2 + int'(cur_done),
                ev * 4 + eb * 2 + ed);
            if (k >= tot) chk({nm, " table"}, int'(cur_tab), exp_tab);
`ifdef SWEEP_CHECK_EN
            if (k == tot) chk({nm, " mismatch"}, int'(cur_mm), (exp_tab != gold) ? 1 : 0);
`endif
            if (k == pulse_at) start_r = 1'b1;
            @(posedge clk);
            #1;
            start_r = 1'b0;
        end
        chk({nm, " busy cycles"}, bcnt, tot);
        chk({nm, " done pulses"}, dcnt, 1);
    endtask

    typedef struct {
        int s;
        int f;
        int exp_tab;
    } vec_t;

    vec_t vt [8];

    initial begin
        int got, bcnt, dcnt;
        vt[0] = '{0, 0, 8'h96};   // parity, DWELL=100
        vt[1] = '{1, 1, 8'hEA};   // (A&B)|C, DWELL=1
        vt[2] = '{2, 3, 8'h08};   // A&B, N_IN=2, DWELL=3
        vt[3] = '{1, 0, 8'h96};
        vt[4] = '{1, 2, 8'h00};   // stuck-at-0
        vt[5] = '{1, 5, 8'hF0};   // Q=A
        vt[6] = '{1, 6, 8'hAA};   // Q=C
        vt[7] = '{2, 0, 8'h06};   // parity, N_IN=2

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset vec %0d", s), cur_vec, 0);
            chk($sformatf("reset busy/done %0d", s), int'({cur_busy, cur_done}), 0);
            chk($sformatf("reset table %0d", s), int'(cur_tab), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fn = vt[i].f;
            run_sweep(vt[i].s, vt[i].exp_tab, -1, $sformatf("vec%0d", i));
        end

        // start during HOLD at vector 5 and during DONE must be ignored
        fn = 0;
        run_sweep(0, 8'h96, 520, "start@v5");
        fn = 1;
        run_sweep(1, 8'hEA, 5, "start@v5 dw1");
        run_sweep(1, 8'hEA, 8, "start@done");

        // start held high: one IDLE cycle, then the next sweep begins at vector 0
        sel = 1;
        fn  = 1;
        @(negedge clk);
        start_r = 1'b1;
        for (int r = 0; r < 2; r++) begin
            got = 0;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(posedge clk);
                #1;
                if (cur_done) got = 1;
            end
            chk($sformatf("held start done %0d", r), got, 1);
            @(posedge clk);
            #1;
            chk($sformatf("held start idle gap %0d", r), int'({cur_busy, cur_done}), 0);
            chk($sformatf("held start table %0d", r), int'(cur_tab), 8'hEA);
            @(posedge clk);
            #1;
            chk($sformatf("held start restart %0d", r), cur_vec * 2 + int'(cur_busy), 1);
        end
        start_r = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("held start settles idle", int'(cur_busy), 0);

        // asynchronous reset in the middle of vector 3
        sel = 0;
        fn  = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (350) @(posedge clk);
        #1;
        chk("pre-reset vec", cur_vec, 3);
        chk("pre-reset partial table", int'(cur_tab), 8'h06);
        #1;
        rst = 1'b1;
        #1;
        chk("mid-reset vec", cur_vec, 0);
        chk("mid-reset busy/done", int'({cur_busy, cur_done}), 0);
        chk("mid-reset table", int'(cur_tab), 0);
        @(negedge clk);
        rst  = 1'b0;
        bcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 900; c++) begin
            @(posedge clk);
            #1;
            bcnt += int'(cur_busy);
            dcnt += int'(cur_done);
        end
        chk("post-reset no busy", bcnt, 0);
        chk("post-reset no done", dcnt, 0);

        // random truth tables through a slow-settling DUT model
        settle_en = 1'b1;
        fn        = 4;
        for (int r = 0; r < 8; r++) begin
            int s;
            s   = $urandom_range(2, 0);
            lut = 8'($urandom);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            run_sweep(s, (s == 2) ? int'(lut[3:0]) : int'(lut), -1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
